// File: rtl/qmult_seq_hs.sv
// Iterative shift-add sign-magnitude Q-format multiplier with valid/ready handshakes on both sides.
// Define QMULT_SAT_EN to saturate the magnitude on overflow; otherwise the magnitude wraps.
module qmult_seq_hs #(
  parameter int N     = 16,
  parameter int Q     = 8,
  parameter int ROUND = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result,
  output logic         o_overflow
);

  localparam int AW = 2*N - 2;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [N-2:0]  mag_a;
  logic [N-2:0]  mag_b;
  logic          sign;
  logic [CW-1:0] count;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;

  logic [N-2:0]  mag_trunc;
  logic [N-1:0]  mag_round;
  logic          round_bit;
  logic          ovf;
  logic [N-2:0]  mag_out;
  logic          unused_low;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    acc_next = acc;
    if (mag_a[count]) acc_next = acc + (AW'(mag_b) << count);
  end

  // Result formatting works on acc_next so the final partial product is included.
  always_comb begin
    mag_trunc = acc_next[N-2+Q:Q];
    round_bit = (ROUND != 0) ? acc_next[Q-1] : 1'b0;
    mag_round = {1'b0, mag_trunc} + {{(N-1){1'b0}}, round_bit};
    ovf       = (|acc_next[AW-1:N-1+Q]) | mag_round[N-1];
`ifdef QMULT_SAT_EN
    mag_out   = ovf ? '1 : mag_round[N-2:0];
`else
    mag_out   = mag_round[N-2:0];
`endif
  end

  // Product bits below the rounding position are dropped by design.
  assign unused_low = ^acc_next;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      o_ready    <= 1'b1;
      o_valid    <= 1'b0;
      o_result   <= '0;
      o_overflow <= 1'b0;
      count      <= '0;
      acc        <= '0;
      mag_a      <= '0;
      mag_b      <= '0;
      sign       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            mag_a   <= i_multiplicand[N-2:0];
            mag_b   <= i_multiplier[N-2:0];
            sign    <= i_multiplicand[N-1] ^ i_multiplier[N-1];
            count   <= '0;
            acc     <= '0;
            o_ready <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          if (count == CW'(N-2)) begin
            o_valid    <= 1'b1;
            o_result   <= {sign & (|mag_out), mag_out};
            o_overflow <= ovf;
            state      <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qmult_seq_hs.sv
// Self-checking bench for qmult_seq_hs: truncating and rounding instances driven in lockstep,
// checked every cycle against an arithmetic reference model plus hand-computed directed cases.
module tb_qmult_seq_hs;

  localparam int N = 16;
  localparam int Q = 8;
`ifdef QMULT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          valid;
  logic          ready_dn;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic          o_ready0, o_ready1;
  logic          o_valid0, o_valid1;
  logic [N-1:0]  o_result0, o_result1;
  logic          o_overflow0, o_overflow1;

  int            n_checks = 0;
  int            n_fail   = 0;

  logic [N-1:0]  exp_res0, exp_res1;
  logic          exp_ovf0, exp_ovf1;
  logic [N-1:0]  got_res0, got_res1;
  logic          got_ovf0, got_ovf1;

  qmult_seq_hs #(.N(N), .Q(Q), .ROUND(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready0),
    .i_multiplicand(op_a), .i_multiplier(op_b), .o_valid(o_valid0), .i_ready(ready_dn),
    .o_result(o_result0), .o_overflow(o_overflow0)
  );

  qmult_seq_hs #(.N(N), .Q(Q), .ROUND(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready1),
    .i_multiplicand(op_a), .i_multiplier(op_b), .o_valid(o_valid1), .i_ready(ready_dn),
    .o_result(o_result1), .o_overflow(o_overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: exact integer product of the magnitudes, scaled, optionally rounded half-up.
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input int rnd);
    longint       p;
    longint       m;
    bit           ov;
    logic [N-2:0] mo;
    bit           s;
    p  = longint'(a[N-2:0]) * longint'(b[N-2:0]);
    m  = (p >> Q) + ((rnd != 0) ? ((p >> (Q-1)) & 64'd1) : 64'd0);
    ov = (m >= (64'd1 << (N-1)));
    mo = (SAT && ov) ? {(N-1){1'b1}} : m[N-2:0];
    s  = (a[N-1] ^ b[N-1]) && (mo != 0);
    return {ov, s, mo};
  endfunction

  // Compare process: whenever a result is presented, it must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid0) begin
        check("res_r0", o_result0, exp_res0);
        check("ovf_r0", o_overflow0, exp_ovf0);
        check("ready_low_in_done_r0", o_ready0, 1'b0);
      end
      if (o_valid1) begin
        check("res_r1", o_result1, exp_res1);
        check("ovf_r1", o_overflow1, exp_ovf1);
      end
    end
  end

  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b, input int hold);
    int  t;
    bit  early;
    t = 0;
    while (!o_ready0 && t < 4*N) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_before_accept", o_ready0, 1'b1);
    op_a     = a;
    op_b     = b;
    valid    = 1'b1;
    ready_dn = (hold == 0);
    {exp_ovf0, exp_res0} = model(a, b, 0);
    {exp_ovf1, exp_res1} = model(a, b, 1);
    @(posedge clk); #1;
    valid = 1'b0;
    op_a  = N'($urandom);
    op_b  = N'($urandom);
    check("busy_ready", {o_ready0, o_ready1}, 2'b00);
    early = 1'b0;
    for (int k = 1; k < N-1; k++) begin
      @(posedge clk); #1;
      early |= o_valid0 | o_valid1;
    end
    check("no_early_valid", early, 1'b0);
    @(posedge clk); #1;
    check("latency_valid", {o_valid0, o_valid1}, 2'b11);
    got_res0 = o_result0; got_ovf0 = o_overflow0;
    got_res1 = o_result1; got_ovf1 = o_overflow1;
    for (int h = 0; h < hold; h++) begin
      valid = 1'b1;
      op_a  = N'($urandom);
      op_b  = N'($urandom);
      @(posedge clk); #1;
      check("hold_valid", {o_valid0, o_valid1, o_ready0, o_ready1}, 4'b1100);
      check("hold_stable_r0", {o_overflow0, o_result0}, {got_ovf0, got_res0});
      check("hold_stable_r1", {o_overflow1, o_result1}, {got_ovf1, got_res1});
    end
    valid    = 1'b0;
    ready_dn = 1'b1;
    if (hold > 0) begin
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    check("release_idle", {o_valid0, o_valid1, o_ready0, o_ready1}, 4'b0011);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  localparam logic [N-1:0] T3_RES  = SAT ? 16'h7FFF : 16'h7E00;
  localparam logic [N-1:0] T4B_RES = SAT ? 16'h7FFF : 16'h0000;

  initial begin
    rst_n    = 1'b0;
    valid    = 1'b0;
    ready_dn = 1'b1;
    op_a     = '0;
    op_b     = '0;
    exp_res0 = '0; exp_res1 = '0; exp_ovf0 = 1'b0; exp_ovf1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {o_ready0, o_valid0, o_overflow0, o_result0}, {3'b100, 16'h0000});
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run(16'h0180, 16'h0200, 0);
    check("t1_res", {got_res0, got_res1}, {16'h0300, 16'h0300});
    check("t1_ovf", {got_ovf0, got_ovf1}, 2'b00);

    run(16'h8180, 16'h0200, 0);
    check("t2a_res", {got_res0, got_res1}, {16'h8300, 16'h8300});
    run(16'h8001, 16'h0001, 0);
    check("t2b_no_neg_zero", {got_res0, got_res1}, {16'h0000, 16'h0000});

    run(16'h7F00, 16'h0200, 0);
    check("t3_ovf", {got_ovf0, got_ovf1}, 2'b11);
    check("t3_res", {got_res0, got_res1}, {T3_RES, T3_RES});

    run(16'h0001, 16'h0080, 0);
    check("t4_round_half", {got_res0, got_res1}, {16'h0000, 16'h0001});
    run(16'h7FFF, 16'h0100, 0);
    check("t4_max_exact", {got_ovf0, got_res0, got_ovf1, got_res1}, {1'b0, 16'h7FFF, 1'b0, 16'h7FFF});
    run(16'h7F80, 16'h0101, 0);
    check("t4_round_carry_ovf", {got_ovf0, got_ovf1}, 2'b01);
    check("t4_round_carry_res", {got_res0, got_res1}, {16'h7FFF, T4B_RES});

    run(16'h0280, 16'h8140, 5);
    check("t5_res", got_res0, 16'h8320);

    // Abort a multiply while BUSY with count = 7.
    op_a = 16'h0300; op_b = 16'h0300; valid = 1'b1;
    {exp_ovf0, exp_res0} = model(16'h0300, 16'h0300, 0);
    {exp_ovf1, exp_res1} = model(16'h0300, 16'h0300, 1);
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", {o_ready0, o_valid0, o_overflow0, o_result0}, {3'b100, 16'h0000});
    check("t6_async_reset_r1", {o_ready1, o_valid1, o_overflow1, o_result1}, {3'b100, 16'h0000});
    @(negedge clk) rst_n = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < N+2; k++) begin
        @(posedge clk); #1;
        seen |= o_valid0 | o_valid1;
      end
      check("t6_result_dropped", seen, 1'b0);
    end
    run(16'h0300, 16'h0300, 0);
    check("t6_fresh", got_res0, 16'h0900);

    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] ra, rb;
      ra = N'($urandom);
      rb = N'($urandom);
      if (i % 2 == 0) begin
        ra[N-2:N-6] = '0;
        rb[N-2:N-6] = '0;
      end
      run(ra, rb, int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
